if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and runs a req/ack handshake to a variable-latency instruction memory. It delivers {pc, instruction, valid} to IF/ID and honours stall from the hazard unit and redirect from branch/jump resolution. Outputs are registered and drive the IF/ID inputs directly; `instr_valid && !stall` is the IF/ID write condition.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
INSTR_WIDTH, 32, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  downstream not accepting; held output must not change
redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  in  ADDR_WIDTH  redirect target
imem_req  out  1  memory request, level
imem_addr  out  ADDR_WIDTH  request address, stable while imem_req high
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  INSTR_WIDTH  fetched instruction
pc_out  out  ADDR_WIDTH  PC of delivered instruction
instr_out  out  INSTR_WIDTH  delivered instruction
instr_valid  out  1  pc_out/instr_out valid

Behaviour:
- Reset (async) forces the following: state=IDLE, imem_req=0, imem_addr=RESET_PC, pc_out=0, instr_out=0, instr_valid=0, pending slot empty, target=RESET_PC. A reset mid-request abandons that request; any late ack is ignored because the unit is in IDLE.
- slot_free = !instr_valid || !stall. This is evaluated from the current-cycle values.
- Consumption: if instr_valid && !stall and nothing new is loaded, instr_valid goes to 0 next cycle. If instr_valid && stall, pc_out and instr_out hold.
- imem_req is 1 in BUSY and DROP only. imem_addr changes only on the cycle after an ack or on entry to BUSY. Requests are never withdrawn before ack. Ack may arrive in the first cycle that req is high.
- Address arithmetic: next address = addr + 4, wrapping modulo 2^ADDR_WIDTH. redirect_pc[1:0] is ignored and forced to 0.
- IDLE state (one cycle after reset):
  - Go to BUSY with imem_addr=target.
  - A redirect here sets target=redirect_pc first.
- BUSY state:
  - ack && !redirect && slot_free: instr_out<=rdata, pc_out<=imem_addr, instr_valid<=1, imem_addr<=imem_addr+4, stay in BUSY. This gives back-to-back requests; throughput is 1 instruction/cycle with a zero-wait memory.
  - ack && !redirect && !slot_free: store rdata and imem_addr in the pending slot, go to HOLD, imem_req<=0.
  - redirect && ack: discard rdata, instr_valid<=0, imem_addr<=redirect_pc, stay in BUSY.
  - redirect && !ack: instr_valid<=0, target<=redirect_pc, go to DROP.
- HOLD state:
  - redirect: discard pending, instr_valid<=0, go to BUSY at redirect_pc.
  - !stall: load pending into outputs, instr_valid<=1, go to BUSY at pending_pc+4.
  - Otherwise: hold.
- DROP state:
  - Keep req high on the old address.
  - A further redirect updates target (last one wins).
  - On ack: discard rdata, go to BUSY at target. If redirect and ack coincide, the new redirect_pc is used.
- Priority: redirect > ack/stall. A redirect always clears instr_valid the next cycle, regardless of stall. This matches the IF/ID flush.
- Invariant: at most one outstanding memory request. A fetched instruction is never delivered after a redirect that followed its request.

Test Plan:
1. Reset and streaming: RESET_PC=0x0, zero-wait memory (ack same cycle), stall=0 -> imem_req rises 1 cycle after reset release; pc_out sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles with instr_valid=1.
2. Stall hold: stall=1 for 3 cycles while pc_out=0x8 valid, memory acks 0xC -> pc_out/instr_out hold 0x8; unit in HOLD with req=0; on stall release 0xC is delivered the next cycle, then a request for 0x10 is issued.
3. Redirect with ack in flight: 3-cycle memory latency, redirect to 0x100 one cycle after the request for 0x10 -> instr_valid=0 next cycle; addr stays 0x10 until ack; data for 0x10 is never delivered; the next request is 0x100 and the first delivered pc_out=0x100.
4. Redirect coincident with ack, and redirect during stall: redirect to 0x200 on the ack cycle -> next imem_addr=0x200; redirect in HOLD -> pending dropped, next delivered pc_out=0x200.
5. Wrap and alignment: redirect_pc=0xFFFFFFFE -> fetch 0xFFFFFFFC, then 0x00000000.
6. Mid-request reset: assert reset while req is high awaiting ack -> all outputs return to reset values immediately; a late ack is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
// program counter, runs a req/ack handshake with a variable-latency
// instruction memory and presents {pc, instruction, valid} to IF/ID.
// All outputs are registered. IF/ID writes when instr_valid && !stall.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   stall        in   IF/ID not accepting; delivered outputs must hold
//   redirect     in   one-cycle pulse: flush and refetch from redirect_pc
//   redirect_pc  in   redirect target (bits [1:0] ignored)
//   imem_req     out  memory request level, high until acknowledged
//   imem_addr    out  request address, stable while imem_req is high
//   imem_ack     in   one-cycle pulse, imem_rdata valid in that cycle
//   imem_rdata   in   fetched instruction word
//   pc_out       out  PC of the delivered instruction
//   instr_out    out  delivered instruction
//   instr_valid  out  pc_out/instr_out hold a live instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid
);

    localparam logic [ADDR_WIDTH-1:0] FETCH_STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    // IDLE: single cycle after reset before the first request.
    // BUSY: request outstanding, result is wanted.
    // HOLD: a fetched word is parked because IF/ID is stalled; no request.
    // DROP: request outstanding but a redirect made its result stale.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetchState_t;

    fetchState_t             state_q;
    logic                    req_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [INSTR_WIDTH-1:0]  instr_q;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   pendPc_q;
    logic [INSTR_WIDTH-1:0]  pendInstr_q;
    logic [ADDR_WIDTH-1:0]   target_q;

    logic [ADDR_WIDTH-1:0]   redirectAligned;
    logic [ADDR_WIDTH-1:0]   addrNext;
    logic                    slotFree;

    // Fetches are word aligned, so the low two redirect bits are dropped.
    assign redirectAligned = redirect_pc & ALIGN_MASK;
    assign addrNext        = addr_q + FETCH_STEP;

    // The output slot can take a new word if it is empty or is being
    // consumed by IF/ID in this very cycle.
    assign slotFree = !valid_q || !stall;

    // Single state machine owning every register of the stage. Redirect is
    // checked first everywhere so a flush always wins over delivery.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            pc_q        <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            pendPc_q    <= '0;
            pendInstr_q <= '0;
            target_q    <= RESET_PC;
        end else begin
            // Baseline: a consumed or flushed instruction leaves the slot;
            // a stalled one stays. Loads below override this.
            valid_q <= valid_q && stall && !redirect;

            case (state_q)
                IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= BUSY;
                    if (redirect) begin
                        target_q <= redirectAligned;
                        addr_q   <= redirectAligned;
                    end else begin
                        addr_q <= target_q;
                    end
                end

                BUSY: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            // Returning word is stale; refetch right away.
                            addr_q <= redirectAligned;
                        end else begin
                            // Cannot withdraw the request, so wait it out.
                            target_q <= redirectAligned;
                            state_q  <= DROP;
                        end
                    end else if (imem_ack) begin
                        if (slotFree) begin
                            pc_q    <= addr_q;
                            instr_q <= imem_rdata;
                            valid_q <= 1'b1;
                            addr_q  <= addrNext;
                        end else begin
                            pendPc_q    <= addr_q;
                            pendInstr_q <= imem_rdata;
                            req_q       <= 1'b0;
                            state_q     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        addr_q  <= redirectAligned;
                        req_q   <= 1'b1;
                        state_q <= BUSY;
                    end else if (!stall) begin
                        pc_q    <= pendPc_q;
                        instr_q <= pendInstr_q;
                        valid_q <= 1'b1;
                        addr_q  <= pendPc_q + FETCH_STEP;
                        req_q   <= 1'b1;
                        state_q <= BUSY;
                    end
                end

                DROP: begin
                    // The latest redirect wins, including one on the ack cycle.
                    if (redirect) begin
                        target_q <= redirectAligned;
                    end
                    if (imem_ack) begin
                        addr_q  <= redirect ? redirectAligned : target_q;
                        state_q <= BUSY;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Drives if_fetch_unit with a latency-programmable instruction memory whose
// contents are a fixed hash of the address. A stream model tracks which PC
// IF/ID must see next; a checker compares the DUT against it every cycle,
// and directed sequences pin exact timing with literal expectations before
// a randomized stall/redirect/latency/reset phase.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int              AW       = 32;
    localparam int              IW       = 32;
    localparam logic [AW-1:0]   RESET_PC = 32'h0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic           stall;
    logic           redirect;
    logic [AW-1:0]  redirect_pc;
    logic           imem_req;
    logic [AW-1:0]  imem_addr;
    logic           imem_ack;
    logic [IW-1:0]  imem_rdata;
    logic [AW-1:0]  pc_out;
    logic [IW-1:0]  instr_out;
    logic           instr_valid;

    logic           memAck;
    logic           lateAck;
    logic [IW-1:0]  memRdata;

    int compared   = 0;
    int mismatched = 0;
    int lat        = 0;
    bit randLat    = 1'b0;

    assign imem_ack   = memAck | lateAck;
    assign imem_rdata = lateAck ? 32'hDEAD_BEEF : memRdata;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .instr_valid (instr_valid)
    );

    // Memory image: every address holds a distinct, reproducible word.
    function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit r, input logic [AW-1:0] rpc);
        @(negedge clk);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < maxCycles);
        if (!instr_valid) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: no instruction delivered within %0d cycles", name, maxCycles);
        end
    endtask

    // Memory responder: acknowledges a held request after 'lat' extra
    // cycles (or a random 0..3 per request), with garbage data otherwise.
    initial begin
        int cnt;
        int curLat;
        cnt      = 0;
        curLat   = 0;
        memAck   = 1'b0;
        memRdata = '0;
        forever begin
            @(negedge clk);
            if (!imem_req) begin
                memAck   = 1'b0;
                memRdata = $urandom;
                cnt      = 0;
            end else begin
                if (cnt == 0) curLat = randLat ? int'($urandom_range(0, 3)) : lat;
                if (cnt >= curLat) begin
                    memAck   = 1'b1;
                    memRdata = memWord(imem_addr);
                    cnt      = 0;
                end else begin
                    memAck   = 1'b0;
                    memRdata = $urandom;
                    cnt++;
                end
            end
        end
    end

    // Stream checker: expPc is the PC that IF/ID must see next. It advances
    // by 4 on each accepted instruction and jumps on every redirect.
    initial begin
        logic [AW-1:0] expPc;
        logic [AW-1:0] prevPc;
        logic [AW-1:0] prevAddr;
        logic [IW-1:0] prevInstr;
        bit            prevValid;
        bit            prevReq;
        int            idleRun;
        expPc     = RESET_PC;
        prevPc    = '0;
        prevAddr  = RESET_PC;
        prevInstr = '0;
        prevValid = 1'b0;
        prevReq   = 1'b0;
        idleRun   = 0;
        forever begin
            tick();
            if (reset) begin
                checkOutput("rst_valid", 32'(instr_valid), 32'd0);
                checkOutput("rst_req", 32'(imem_req), 32'd0);
                checkOutput("rst_addr", imem_addr, RESET_PC);
                checkOutput("rst_pc", pc_out, 32'd0);
                checkOutput("rst_instr", instr_out, 32'd0);
                expPc     = RESET_PC;
                prevValid = 1'b0;
                prevReq   = 1'b0;
                prevAddr  = RESET_PC;
                idleRun   = 0;
            end else begin
                if (prevValid && !stall) expPc += 32'd4;
                if (redirect) begin
                    expPc = redirect_pc & ~32'h3;
                    checkOutput("flush_valid", 32'(instr_valid), 32'd0);
                end else if (prevValid && stall) begin
                    checkOutput("hold_valid", 32'(instr_valid), 32'd1);
                    checkOutput("hold_pc", pc_out, prevPc);
                    checkOutput("hold_instr", instr_out, prevInstr);
                end
                if (instr_valid) begin
                    checkOutput("stream_pc", pc_out, expPc);
                    checkOutput("stream_instr", instr_out, memWord(expPc));
                end
                if (prevReq && !imem_ack) begin
                    checkOutput("req_held", 32'(imem_req), 32'd1);
                    checkOutput("addr_stable", imem_addr, prevAddr);
                end
                if (instr_valid || redirect) idleRun = 0;
                else idleRun++;
                if (idleRun > 25) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL liveness: no delivery for %0d cycles", idleRun);
                    idleRun = 0;
                end
                prevValid = instr_valid;
                prevReq   = imem_req;
                prevAddr  = imem_addr;
                prevPc    = pc_out;
                prevInstr = instr_out;
            end
        end
    end

    // Watchdog so a wedged run still terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] rpc;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        lateAck     = 1'b0;

        // Reset release and zero-wait streaming.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t1_req_before", 32'(imem_req), 32'd0);
        tick();
        checkOutput("t1_req_rise", 32'(imem_req), 32'd1);
        checkOutput("t1_addr0", imem_addr, 32'h0);
        checkOutput("t1_valid0", 32'(instr_valid), 32'd0);
        tick();
        checkOutput("t1_pc0", pc_out, 32'h0);
        checkOutput("t1_v0", 32'(instr_valid), 32'd1);
        checkOutput("t1_instr0", instr_out, 32'h5A5A_1234);
        tick();
        checkOutput("t1_pc4", pc_out, 32'h4);
        checkOutput("t1_instr4", instr_out, 32'h2287_F4F0);
        tick();
        checkOutput("t1_pc8", pc_out, 32'h8);
        tick();
        checkOutput("t1_pcC", pc_out, 32'hC);
        checkOutput("t1_vC", 32'(instr_valid), 32'd1);

        // Stall hold with a parked word.
        doReset();
        repeat (4) tick();
        checkOutput("t2_pc8", pc_out, 32'h8);
        applyStimulus(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t2_hold_pc", pc_out, 32'h8);
            checkOutput("t2_hold_valid", 32'(instr_valid), 32'd1);
            checkOutput("t2_hold_req", 32'(imem_req), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, '0);
        lat = 2;
        tick();
        checkOutput("t2_pcC", pc_out, 32'hC);
        checkOutput("t2_vC", 32'(instr_valid), 32'd1);
        checkOutput("t2_req", 32'(imem_req), 32'd1);
        checkOutput("t2_addr10", imem_addr, 32'h10);

        // Redirect while a slow request is in flight.
        applyStimulus(1'b0, 1'b1, 32'h100);
        tick();
        checkOutput("t3_flush", 32'(instr_valid), 32'd0);
        checkOutput("t3_addr_keep", imem_addr, 32'h10);
        applyStimulus(1'b0, 1'b0, '0);
        tick();
        checkOutput("t3_addr_keep2", imem_addr, 32'h10);
        tick();
        checkOutput("t3_addr100", imem_addr, 32'h100);
        checkOutput("t3_req", 32'(imem_req), 32'd1);
        waitValid("t3_deliver", 10);
        checkOutput("t3_pc100", pc_out, 32'h100);

        // Redirect on the ack cycle, then redirect while parked in HOLD.
        tick();
        tick();
        checkOutput("t4_addr104", imem_addr, 32'h104);
        applyStimulus(1'b0, 1'b1, 32'h200);
        tick();
        checkOutput("t4_addr200", imem_addr, 32'h200);
        checkOutput("t4_flush", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, '0);
        waitValid("t4_deliver", 10);
        checkOutput("t4_pc200", pc_out, 32'h200);
        applyStimulus(1'b1, 1'b0, '0);
        for (int i = 0; i < 6 && imem_req; i++) tick();
        checkOutput("t4_hold_req", 32'(imem_req), 32'd0);
        checkOutput("t4_hold_pc", pc_out, 32'h200);
        applyStimulus(1'b1, 1'b1, 32'h200);
        tick();
        checkOutput("t4_hold_flush", 32'(instr_valid), 32'd0);
        checkOutput("t4_refetch", imem_addr, 32'h200);
        applyStimulus(1'b0, 1'b0, '0);
        waitValid("t4_redeliver", 10);
        checkOutput("t4_pc200b", pc_out, 32'h200);

        // Alignment and address wrap.
        lat = 0;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 1'b0, '0);
        waitValid("t5_deliver", 10);
        checkOutput("t5_pcFFFC", pc_out, 32'hFFFF_FFFC);
        tick();
        checkOutput("t5_wrap_pc", pc_out, 32'h0);
        checkOutput("t5_wrap_valid", 32'(instr_valid), 32'd1);
        checkOutput("t5_wrap_instr", instr_out, 32'h5A5A_1234);

        // Reset in the middle of a request, with a late ack after release.
        lat = 3;
        tick();
        tick();
        checkOutput("t6_req_pending", 32'(imem_req), 32'd1);
        checkOutput("t6_no_ack", 32'(imem_ack), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_req", 32'(imem_req), 32'd0);
        checkOutput("t6_rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("t6_rst_addr", imem_addr, RESET_PC);
        checkOutput("t6_rst_pc", pc_out, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        lateAck = 1'b1;
        tick();
        checkOutput("t6_late_valid", 32'(instr_valid), 32'd0);
        checkOutput("t6_restart_addr", imem_addr, RESET_PC);
        checkOutput("t6_restart_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        lateAck = 1'b0;
        waitValid("t6_deliver", 12);
        checkOutput("t6_pc", pc_out, RESET_PC);
        checkOutput("t6_instr", instr_out, 32'h5A5A_1234);

        // Randomized stall / redirect / latency / occasional reset.
        randLat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else rpc = $urandom;
                applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 6, rpc);
            end
        end
        applyStimulus(1'b0, 1'b0, '0);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
